timer_prog_sequencer: RTL

- Bus-master controller that programs and samples one timer_unit instance over the timer's req/gnt/r_valid slave port.
- Takes single-beat commands from the core-side control logic:
  - PROGRAM: stop, load compare, reset count, write config.
  - READ: sample the counter value.
- Expands each command into the ordered register accesses and returns one completion response.
- Filters responses by transaction ID and guards every access with a response-timeout watchdog.

---
 rtl/timer_seq_pkg.sv | 56 +++++
 rtl/timer_seq_watchdog.sv | 29 ++
 rtl/timer_prog_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/timer_seq_pkg.sv
// Register map, cfg bit positions and shared types for the timer_unit programming sequencer.
// step_access() maps (command, step) to the bus access that step performs.
package timer_seq_pkg;

  localparam logic [7:0] REG_CFG    = 8'h00;
  localparam logic [7:0] REG_VAL    = 8'h08;
  localparam logic [7:0] REG_CMP    = 8'h10;
  localparam logic [7:0] REG_START  = 8'h18;
  localparam logic [7:0] REG_RESET  = 8'h20;
  localparam logic [7:0] REG_HI_OFS = 8'h04;

  localparam int CFG_ENABLE        = 0;
  localparam int CFG_RESET         = 1;
  localparam int CFG_IRQ           = 2;
  localparam int CFG_IEM           = 3;
  localparam int CFG_CMP_CLR       = 4;
  localparam int CFG_ONE_SHOT      = 5;
  localparam int CFG_PRESCALER_EN  = 6;
  localparam int CFG_REF_CLK_EN    = 7;
  localparam int CFG_PRESCALER_LSB = 8;
  localparam int CFG_PRESCALER_MSB = 15;
  localparam int CFG_MODE_64       = 31;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_e;
  typedef enum logic {OP_PROGRAM = 1'b0, OP_READ = 1'b1} op_e;

  typedef struct packed {
    logic [7:0]  offs;
    logic        wen;
    logic [31:0] wdata;
  } acc_t;

  function automatic acc_t step_access(op_e op, logic hi, logic [1:0] step,
                                       logic [31:0] cmp, logic [31:0] cfg);
    acc_t       a;
    logic [7:0] hofs;
    hofs    = hi ? REG_HI_OFS : 8'h00;
    a.offs  = REG_CFG + hofs;
    a.wen   = 1'b0;
    a.wdata = '0;
    if (op == OP_READ) begin
      a.offs = REG_VAL + hofs;
      a.wen  = 1'b1;
    end else begin
      // Timer is stopped before compare/count are touched, then re-enabled last.
      case (step)
        2'd0: a.wdata = cfg & ~(32'h1 << CFG_ENABLE);
        2'd1: begin a.offs = REG_CMP + hofs;   a.wdata = cmp;   end
        2'd2: begin a.offs = REG_RESET + hofs; a.wdata = 32'h1; end
        default: a.wdata = cfg;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/timer_seq_watchdog.sv
// Response watchdog: loaded with TIMEOUT on grant, counts down while waiting; expire_o marks
// the TIMEOUT-th waiting cycle. TIMEOUT = 0 disables expiry.
module timer_seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(TIMEOUT);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire_o = (TIMEOUT != 0) && run_i && (cnt_q == CW'(1));

endmodule

// File: rtl/timer_prog_sequencer.sv
// Expands PROGRAM/READ commands into timer_unit bus accesses, one outstanding at a time.
// Accept at T gives req at T+1 and rsp at T+1+2N on a zero-wait bus; rsp has no backpressure.
module timer_prog_sequencer
  import timer_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ID_WIDTH  = 5,
  parameter int          TIMEOUT   = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_op_i,
  input  logic                cmd_hi_i,
  input  logic [31:0]         cmd_cmp_i,
  input  logic [31:0]         cmd_cfg_i,
  output logic                rsp_valid_o,
  output logic                rsp_err_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                busy_o,
  output logic                req_o,
  output logic [31:0]         addr_o,
  output logic                wen_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          be_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic                r_opc_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  input  logic [31:0]         r_rdata_i
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic                hi_q;
  logic [31:0]         cmp_q, cfg_q;
  logic [1:0]          step_q;
  logic [ID_WIDTH-1:0] id_cnt_q, iss_id_q;
  logic                err_q;
  logic [31:0]         rdata_q, addr_q, wdata_q;
  logic                wen_q;

  logic accept, granted, rsp_match, rsp_ok, rsp_bad, last_step, advance, wd_expire;
  acc_t acc_next;

  assign accept    = (state_q == IDLE) && cmd_valid_i;
  assign granted   = (state_q == ISSUE) && gnt_i;
  assign rsp_match = (state_q == WAIT_RSP) && r_valid_i && (r_id_i == iss_id_q);
  assign rsp_ok    = rsp_match && !r_opc_i;
  assign rsp_bad   = rsp_match && r_opc_i;
  assign last_step = (op_q == OP_READ) || (step_q == 2'd3);
  assign advance   = rsp_ok && !last_step;

  timer_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (granted),
    .run_i    (state_q == WAIT_RSP),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A matching response wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid_i) state_d = ISSUE;
      ISSUE:    if (gnt_i) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_ok)                     state_d = last_step ? DONE : ISSUE;
        else if (rsp_bad || wd_expire)  state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next access comes from the live command on accept, else from the latched one.
  always_comb begin
    acc_next = step_access(op_q, hi_q, step_q + 2'd1, cmp_q, cfg_q);
    if (state_q == IDLE) begin
      acc_next = step_access(op_e'(cmd_op_i), cmd_hi_i, 2'd0, cmd_cmp_i, cmd_cfg_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= OP_PROGRAM;
      hi_q     <= 1'b0;
      cmp_q    <= '0;
      cfg_q    <= '0;
      step_q   <= '0;
      id_cnt_q <= '0;
      iss_id_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(cmd_op_i);
        hi_q    <= cmd_hi_i;
        cmp_q   <= cmd_cmp_i;
        cfg_q   <= cmd_cfg_i;
        step_q  <= '0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
      if (accept || advance) begin
        addr_q  <= BASE_ADDR + {24'h0, acc_next.offs};
        wen_q   <= acc_next.wen;
        wdata_q <= acc_next.wdata;
      end
      if (advance) step_q <= step_q + 2'd1;
      if (granted) begin
        iss_id_q <= id_cnt_q;
        id_cnt_q <= id_cnt_q + ID_WIDTH'(1);
      end
      if (rsp_ok && (op_q == OP_READ)) rdata_q <= r_rdata_i;
      if ((state_q == WAIT_RSP) && !rsp_ok && (rsp_bad || wd_expire)) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign req_o       = (state_q == ISSUE);
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;
  assign addr_o      = addr_q;
  assign wen_o       = wen_q;
  assign wdata_o     = wdata_q;
  assign be_o        = 4'hF;
  assign id_o        = id_cnt_q;

endmodule
